// File: rtl/wall_scroller_if.sv
// Control/status bundle between the game FSM (master) and the wall engine (slave).
interface wall_scroller_if #(
  parameter int unsigned NUM_WALLS = 2,
  parameter int unsigned X_W       = 8,
  parameter int unsigned Y_W       = 7
) ();

  logic                     start;
  logic                     pause;
  logic                     advance;
  logic [NUM_WALLS*X_W-1:0] x_out;
  logic [NUM_WALLS*Y_W-1:0] hole_y_out;
  logic [NUM_WALLS-1:0]     active;
  logic                     tick;
  logic                     pass_pulse;
  logic [7:0]               score;
  logic                     running;

  modport master (
    output start, pause, advance,
    input  x_out, hole_y_out, active, tick, pass_pulse, score, running
  );

  modport slave (
    input  start, pause, advance,
    output x_out, hole_y_out, active, tick, pass_pulse, score, running
  );

endinterface

// File: rtl/wall_scroller.sv
// Multi-wall obstacle engine: scrolls walls left on a divided tick, respawns them with a
// pseudo-random hole and scores bird-column crossings. Optional macro: WALL_SPEEDUP_EN.
module wall_scroller #(
  parameter int unsigned NUM_WALLS    = 2,
  parameter int unsigned X_W          = 8,
  parameter int unsigned Y_W          = 7,
  parameter int unsigned SCREEN_W     = 160,
  parameter int unsigned WALL_SPEED   = 4,
  parameter int unsigned TICK_DIV     = 128,
  parameter int unsigned HOLE_MIN     = 8,
  parameter int unsigned HOLE_RANGE   = 64,
  parameter int unsigned WALL_SPACING = 80,
  parameter int unsigned BIRD_X       = 40
) (
  input  logic           clk,
  input  logic           reset,
  wall_scroller_if.slave bus
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam int unsigned IdxW = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1;

  localparam logic [X_W-1:0]  ScreenX  = X_W'(SCREEN_W);
  localparam logic [X_W-1:0]  BirdX    = X_W'(BIRD_X);
  localparam logic [Y_W-1:0]  HoleBase = Y_W'(HOLE_MIN);
  localparam logic [Y_W-1:0]  HoleMask = Y_W'(HOLE_RANGE - 1);
  localparam logic [CntW-1:0] CntLast  = CntW'(TICK_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_WALLS - 1);

  typedef enum logic [1:0] {StIdle, StSpawn, StRun, StPaused} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [X_W-1:0]      x_q [NUM_WALLS];
  logic [X_W-1:0]      x_d [NUM_WALLS];
  logic [Y_W-1:0]      hole_q [NUM_WALLS];
  logic [Y_W-1:0]      hole_d [NUM_WALLS];
  logic [NUM_WALLS-1:0] active_q, active_d;
  logic [7:0]          score_q, score_d;
  logic                tick_q, tick_d;
  logic                pass_q, pass_d;
  logic [15:0]         lfsr_q, lfsr_d;

  logic                do_update;
  logic [X_W-1:0]      speed;
  logic [X_W-1:0]      x_step;
  logic [2:0]          n_pass;
  logic [8:0]          score_sum;
  logic [Y_W-1:0]      hole_sample;

  // Galois form of x^16+x^14+x^13+x^11+1; free-runs in every state.
  assign lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign hole_sample = HoleBase + (lfsr_q[Y_W-1:0] & HoleMask);

`ifdef WALL_SPEEDUP_EN
  logic [8:0] speed_raw;

  always_comb begin
    speed_raw = 9'(WALL_SPEED) + {4'd0, score_q[7:3]};
    speed     = (speed_raw > 9'd15) ? X_W'(15) : X_W'(speed_raw);
  end
`else
  assign speed = X_W'(WALL_SPEED);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    x_d       = x_q;
    hole_d    = hole_q;
    active_d  = active_q;
    score_d   = score_q;
    tick_d    = 1'b0;
    pass_d    = 1'b0;
    do_update = 1'b0;

    if (bus.start) begin
      state_d  = StSpawn;
      cnt_d    = '0;
      idx_d    = '0;
      active_d = '0;
      score_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StSpawn: begin
          for (int unsigned w = 0; w < NUM_WALLS; w++) begin
            if (idx_q == IdxW'(w)) begin
              x_d[w]      = X_W'(SCREEN_W + w * WALL_SPACING);
              hole_d[w]   = hole_sample;
              active_d[w] = 1'b1;
            end
          end
          if (idx_q == IdxLast) begin
            state_d = StRun;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
        StRun: begin
          // Pause wins over counting so a frozen run never sneaks in one more step.
          if (bus.pause) begin
            state_d = StPaused;
          end else if (bus.advance) begin
            if (cnt_q == CntLast) begin
              cnt_d     = '0;
              do_update = 1'b1;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        StPaused: begin
          if (!bus.pause) begin
            state_d = StRun;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    n_pass    = '0;
    x_step    = '0;
    score_sum = '0;
    if (do_update) begin
      tick_d = 1'b1;
      for (int unsigned w = 0; w < NUM_WALLS; w++) begin
        if (x_q[w] > speed) begin
          x_step = x_q[w] - speed;
          x_d[w] = x_step;
          if ((x_q[w] >= BirdX) && (x_step < BirdX)) begin
            n_pass = n_pass + 3'd1;
          end
        end else begin
          // A respawning wall never counts as a pass.
          x_d[w]    = ScreenX;
          hole_d[w] = hole_sample;
        end
      end
      pass_d    = (n_pass != 3'd0);
      score_sum = {1'b0, score_q} + {6'd0, n_pass};
      score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      x_q      <= '{default: '0};
      hole_q   <= '{default: '0};
      active_q <= '0;
      score_q  <= '0;
      tick_q   <= 1'b0;
      pass_q   <= 1'b0;
      lfsr_q   <= 16'hACE1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      x_q      <= x_d;
      hole_q   <= hole_d;
      active_q <= active_d;
      score_q  <= score_d;
      tick_q   <= tick_d;
      pass_q   <= pass_d;
      lfsr_q   <= lfsr_d;
    end
  end

  logic [NUM_WALLS*X_W-1:0] x_packed;
  logic [NUM_WALLS*Y_W-1:0] hole_packed;

  always_comb begin
    x_packed    = '0;
    hole_packed = '0;
    for (int unsigned w = 0; w < NUM_WALLS; w++) begin
      x_packed[w*X_W +: X_W]    = x_q[w];
      hole_packed[w*Y_W +: Y_W] = hole_q[w];
    end
  end

  assign bus.x_out      = x_packed;
  assign bus.hole_y_out = hole_packed;
  assign bus.active     = active_q;
  assign bus.tick       = tick_q;
  assign bus.pass_pulse = pass_q;
  assign bus.score      = score_q;
  assign bus.running    = (state_q == StRun) || (state_q == StPaused);

endmodule
